// File: rtl/y86_pkg.sv
// Shared Y86-64 writeback types: register/status codes and the queued result entry.
package y86_pkg;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [2:0] SHLT  = 3'd2;
  localparam logic [2:0] SADR  = 3'd3;
  localparam logic [2:0] SINS  = 3'd4;
  localparam int         WB_DW = 64;

  typedef struct packed {
    logic [2:0]       stat;
    logic [3:0]       dstE;
    logic [WB_DW-1:0] valE;
    logic [3:0]       dstM;
    logic [WB_DW-1:0] valM;
  } wb_entry_t;
endpackage

// File: rtl/y86_wb_fifo.sv
// In-order result queue for the writeback unit. With Y86_WB_FWD_EN defined it also
// presents all slots oldest-first so the top can search pending results.
module y86_wb_fifo
  import y86_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic [AW:0] count,
  output logic      full,
  output logic      empty
`ifdef Y86_WB_FWD_EN
  ,
  output wb_entry_t ordered [DEPTH]
`endif
);
  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

`ifdef Y86_WB_FWD_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ordered[i] = mem[rd_ptr + AW'(i)];
  end
`endif
endmodule

// File: rtl/y86_writeback_unit.sv
// Y86-64 writeback: queues results, retires one per cycle onto registered regfile ports.
// Optional forwarding lookup to decode is enabled by defining Y86_WB_FWD_EN.
module y86_writeback_unit
  import y86_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int DW    = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  // Handshake: a result transfers on a rising edge where in_valid && in_ready;
  // in_ready never depends on in_valid, and a full queue refuses even while popping.
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_stat,
  input  logic [3:0]    in_dstE,
  input  logic [DW-1:0] in_valE,
  input  logic [3:0]    in_dstM,
  input  logic [DW-1:0] in_valM,
  input  logic          drain_en,
  output logic [3:0]    dstE,
  output logic [DW-1:0] valE,
  output logic [3:0]    dstM,
  output logic [DW-1:0] valM,
  output logic          halted,
  output logic [AW:0]   pending
`ifdef Y86_WB_FWD_EN
  ,
  input  logic [3:0]    srcA,
  input  logic [3:0]    srcB,
  output logic          fwdA_hit,
  output logic [DW-1:0] fwdA_val,
  output logic          fwdB_hit,
  output logic [DW-1:0] fwdB_val
`endif
);
  wb_entry_t in_entry;
  wb_entry_t head;
  logic      push;
  logic      pop;
  logic      full;
  logic      empty;

  assign in_entry = '{stat: in_stat, dstE: in_dstE, valE: WB_DW'(in_valE),
                      dstM: in_dstM, valM: WB_DW'(in_valM)};
  assign in_ready = !full && !halted;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && drain_en && !halted;

`ifdef Y86_WB_FWD_EN
  wb_entry_t ordered [DEPTH];
`endif

  y86_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .din    (in_entry),
    .head   (head),
    .count  (pending),
    .full   (full),
    .empty  (empty)
`ifdef Y86_WB_FWD_EN
    ,
    .ordered(ordered)
`endif
  );

  // Destinations fall back to RNONE every cycle so each regfile write lasts one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      dstE   <= RNONE;
      dstM   <= RNONE;
      valE   <= '0;
      valM   <= '0;
      halted <= 1'b0;
    end else begin
      dstE <= RNONE;
      dstM <= RNONE;
      if (pop) begin
        if (head.stat == SAOK) begin
          dstE <= head.dstE;
          valE <= head.valE[DW-1:0];
          dstM <= head.dstM;
          valM <= head.valM[DW-1:0];
        end else begin
          halted <= 1'b1;
        end
      end
    end
  end

`ifdef Y86_WB_FWD_EN
  // Scan oldest to newest so later matches overwrite; dstM checked after dstE wins ties.
  function automatic logic [DW:0] lookup(input logic [3:0] src);
    logic [DW:0] r;
    r = '0;
    if (src != RNONE) begin
      if (dstE == src) r = {1'b1, valE};
      if (dstM == src) r = {1'b1, valM};
      for (int i = 0; i < DEPTH; i++) begin
        if (i < int'(pending) && ordered[i].stat == SAOK) begin
          if (ordered[i].dstE == src) r = {1'b1, ordered[i].valE[DW-1:0]};
          if (ordered[i].dstM == src) r = {1'b1, ordered[i].valM[DW-1:0]};
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    {fwdA_hit, fwdA_val} = lookup(srcA);
    {fwdB_hit, fwdB_val} = lookup(srcB);
  end
`endif
endmodule

// File: tb/tb_y86_writeback_unit.sv
// Bench for y86_writeback_unit: directed scenarios then random traffic against a queue model.
// Forwarding checks are compiled in when Y86_WB_FWD_EN is defined.
module tb_y86_writeback_unit;
  localparam int DEPTH = 4;
  localparam int DW    = 64;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
  } tb_ent_t;
  localparam int EW = $bits(tb_ent_t);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_stat = 3'd1;
  logic [3:0]    in_dstE = 4'hF;
  logic [DW-1:0] in_valE = '0;
  logic [3:0]    in_dstM = 4'hF;
  logic [DW-1:0] in_valM = '0;
  logic          drain_en = 1'b0;
  logic [3:0]    dstE;
  logic [DW-1:0] valE;
  logic [3:0]    dstM;
  logic [DW-1:0] valM;
  logic          halted;
  logic [AW:0]   pending;
`ifdef Y86_WB_FWD_EN
  logic [3:0]    srcA = 4'hF;
  logic [3:0]    srcB = 4'hF;
  logic          fwdA_hit;
  logic [DW-1:0] fwdA_val;
  logic          fwdB_hit;
  logic [DW-1:0] fwdB_val;
`endif

  y86_writeback_unit #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clock   (clock),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_stat (in_stat),
    .in_dstE (in_dstE),
    .in_valE (in_valE),
    .in_dstM (in_dstM),
    .in_valM (in_valM),
    .drain_en(drain_en),
    .dstE    (dstE),
    .valE    (valE),
    .dstM    (dstM),
    .valM    (valM),
    .halted  (halted),
    .pending (pending)
`ifdef Y86_WB_FWD_EN
    ,
    .srcA    (srcA),
    .srcB    (srcB),
    .fwdA_hit(fwdA_hit),
    .fwdA_val(fwdA_val),
    .fwdB_hit(fwdB_hit),
    .fwdB_val(fwdB_val)
`endif
  );

  // Clock
  always #5 clock = ~clock;

  // Scoreboard / reference model state
  logic [EW-1:0] exp_q[$];
  logic [3:0]    e_dstE = 4'hF, e_dstM = 4'hF;
  logic [63:0]   e_valE = '0, e_valM = '0;
  logic          e_halted = 1'b0;
  logic          val_known = 1'b1;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Newest queued result first, then what is on the write ports; M beats E in an entry.
  task automatic fwd_model(input logic [3:0] src, output logic hit, output logic [63:0] val);
    tb_ent_t e;
    hit = 1'b0;
    val = '0;
    if (src != 4'hF) begin
      for (int i = exp_q.size() - 1; i >= 0 && !hit; i--) begin
        e = tb_ent_t'(exp_q[i]);
        if (e.stat == 3'd1) begin
          if (e.dm == src) begin hit = 1'b1; val = e.vm; end
          else if (e.de == src) begin hit = 1'b1; val = e.ve; end
        end
      end
      if (!hit) begin
        if (e_dstM == src) begin hit = 1'b1; val = e_valM; end
        else if (e_dstE == src) begin hit = 1'b1; val = e_valE; end
      end
    end
  endtask

  // One clock: check combinational outputs, advance, update model, check registered outputs.
  task automatic step();
    logic    acc, pop, rdy;
    tb_ent_t e;
`ifdef Y86_WB_FWD_EN
    logic        h;
    logic [63:0] v;
`endif
    #1;
    rdy = (exp_q.size() < DEPTH) && !e_halted;
    acc = in_valid && rdy && !reset;
    pop = (exp_q.size() > 0) && drain_en && !e_halted;
    chk("in_ready", in_ready, rdy);
`ifdef Y86_WB_FWD_EN
    fwd_model(srcA, h, v);
    chk("fwdA_hit", fwdA_hit, h);
    chk("fwdA_val", fwdA_val, v);
    fwd_model(srcB, h, v);
    chk("fwdB_hit", fwdB_hit, h);
    chk("fwdB_val", fwdB_val, v);
`endif
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      e_dstE = 4'hF; e_dstM = 4'hF;
      e_valE = '0;   e_valM = '0;
      e_halted = 1'b0;
      val_known = 1'b1;
    end else begin
      e_dstE = 4'hF;
      e_dstM = 4'hF;
      if (pop) begin
        e = tb_ent_t'(exp_q.pop_front());
        if (e.stat == 3'd1) begin
          e_dstE = e.de; e_valE = e.ve;
          e_dstM = e.dm; e_valM = e.vm;
          val_known = 1'b1;
        end else begin
          e_halted = 1'b1;
          val_known = 1'b0;
        end
      end
      if (acc) exp_q.push_back({in_stat, in_dstE, in_valE, in_dstM, in_valM});
    end
    #1;
    chk("pending", pending, exp_q.size());
    chk("dstE", dstE, e_dstE);
    chk("dstM", dstM, e_dstM);
    chk("halted", halted, e_halted);
    if (val_known) begin
      chk("valE", valE, e_valE);
      chk("valM", valM, e_valM);
    end
    if (acc) in_valid = 1'b0;
  endtask

  task automatic offer(input logic [2:0] s, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    in_valid = 1'b1;
    in_stat = s; in_dstE = de; in_valE = ve; in_dstM = dm; in_valM = vm;
  endtask

  task automatic push_wait(input logic [2:0] s, input logic [3:0] de, input logic [63:0] ve,
                           input logic [3:0] dm, input logic [63:0] vm);
    offer(s, de, ve, dm, vm);
    for (int n = 0; n < 20 && in_valid; n++) step();
    chk("accept_timeout", in_valid, 1'b0);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_valE", valE, 64'h0);
    chk("rst_valM", valM, 64'h0);
    reset = 1'b0;
    step();

    // Single result: ports show it after k+1 only
    drain_en = 1'b1;
    offer(3'd1, 4'd3, 64'h11, 4'hF, 64'h0);
    step();
    step();
    chk("t2_dstE_k1", dstE, 4'd3);
    chk("t2_valE_k1", valE, 64'h11);
    step();
    chk("t2_dstE_k2", dstE, 4'hF);

    // Fill with drain off, fifth offer held, then drain in order
    drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_wait(3'd1, 4'(i + 5), 64'($urandom), 4'hF, 64'h0);
    chk("t3_ready_full", in_ready, 1'b0);
    offer(3'd1, 4'd10, 64'hCAFE, 4'd11, 64'hBEEF);
    step();
    step();
    chk("t3_held", in_valid, 1'b1);
    drain_en = 1'b1;
    for (int n = 0; n < 8; n++) step();
    chk("t3_drained", pending, 0);

    // Full + push/pop attempt refuses; empty + push/drain goes 0->1->0
    drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_wait(3'd1, 4'd1, 64'(i), 4'd2, 64'(i + 100));
    drain_en = 1'b1;
    offer(3'd1, 4'd9, 64'h99, 4'hF, 64'h0);
    step();
    chk("t6_full_pending", pending, DEPTH - 1);
    for (int n = 0; n < 8; n++) step();
    offer(3'd1, 4'd6, 64'h66, 4'hF, 64'h0);
    step();
    chk("t6_pending1", pending, 1);
    step();
    chk("t6_pending0", pending, 0);
    chk("t6_dstE", dstE, 4'd6);

    // Halt: r1 written, r2 never, r4 stays queued
    drain_en = 1'b0;
    push_wait(3'd1, 4'd1, 64'h5, 4'hF, 64'h0);
    push_wait(3'd2, 4'd2, 64'h7, 4'hF, 64'h0);
    push_wait(3'd1, 4'd4, 64'h9, 4'hF, 64'h0);
    drain_en = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      if (dstE == 4'd2) chk("t4_r2_written", dstE, 4'hF);
    end
    chk("t4_halted", halted, 1'b1);
    chk("t4_pending", pending, 1);
    offer(3'd1, 4'd7, 64'h77, 4'hF, 64'h0);
    step();
    in_valid = 1'b0;

    // Reset mid-burst with three queued
    reset = 1'b1;
    step();
    reset = 1'b0;
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) push_wait(3'd1, 4'(i), 64'($urandom), 4'(i + 8), 64'($urandom));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t1_pending", pending, 0);
    chk("t1_ready", in_ready, 1'b1);
    chk("t1_dstM", dstM, 4'hF);

`ifdef Y86_WB_FWD_EN
    // Forwarding: newest r4 wins; dstE==dstM returns valM
    push_wait(3'd1, 4'd4, 64'hA, 4'hF, 64'h0);
    push_wait(3'd1, 4'd4, 64'hB, 4'hF, 64'h0);
    srcA = 4'd4;
    srcB = 4'hF;
    #1;
    chk("t5_hitA", fwdA_hit, 1'b1);
    chk("t5_valA", fwdA_val, 64'hB);
    chk("t5_missB", fwdB_hit, 1'b0);
    push_wait(3'd1, 4'd4, 64'hC, 4'd4, 64'hD);
    #1;
    chk("t5_valM", fwdA_val, 64'hD);
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset = (e_halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
      if (!in_valid || $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1)
          offer(($urandom_range(0, 29) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
                4'($urandom_range(0, 15)), {$urandom, $urandom},
                4'($urandom_range(0, 15)), {$urandom, $urandom});
        else
          in_valid = 1'b0;
      end
      drain_en = ($urandom_range(0, 3) != 0);
`ifdef Y86_WB_FWD_EN
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
